// File: rtl/dsp_pkg.sv
// Shared types and constants for the two-requester DSP-slice arbiter.
package dsp_pkg;

  localparam int A_W = 18;
  localparam int B_W = 18;
  localparam int C_W = 48;
  localparam int P_W = 48;

  localparam logic [7:0] OPMODE_IDLE = 8'h00;
  localparam logic [7:0] OPMODE_MUL  = 8'h01;
  localparam logic [7:0] OPMODE_MADD = 8'h0D;

  // One tag rides alongside each issued operation through the DSP pipeline.
  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

  function automatic logic [7:0] opmode_of(input logic op);
    return op ? OPMODE_MADD : OPMODE_MUL;
  endfunction

endpackage

// File: rtl/dsp_tag_pipe.sv
// Tag shift register that tracks which requester owns each operation in the
// DSP pipeline; its output lines up with the matching result on P_IN.
module dsp_tag_pipe
  import dsp_pkg::*;
#(
  parameter int PIPE_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_id,
  output logic out_valid,
  output logic out_id,
  output logic any_valid
);

  tag_t                stage_reg [PIPE_LAT];
  tag_t                head;
  logic [PIPE_LAT-1:0] valid_vec;

  always_comb begin
    head       = '0;
    head.valid = in_valid;
    head.id    = in_id;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        stage_reg[i] <= '0;
      end
    end else begin
      stage_reg[0] <= head;
      for (int i = 1; i < PIPE_LAT; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < PIPE_LAT; gi++) begin : g_valid
      assign valid_vec[gi] = stage_reg[gi].valid;
    end
  endgenerate

  assign any_valid = |valid_vec;
  assign out_valid = stage_reg[PIPE_LAT-1].valid;
  assign out_id    = stage_reg[PIPE_LAT-1].id;

endmodule

// File: rtl/dsp_share_arbiter.sv
// Round-robin sharing of one DSP slice between two requesters, with result
// routing by tag. Optional requester lock when DSP_ARB_LOCK_EN is defined.
module dsp_share_arbiter
  import dsp_pkg::*;
#(
  parameter int PIPE_LAT = 4  // legal 1..8
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           VALID0,
  input  logic           VALID1,
  output logic           READY0,
  output logic           READY1,
  input  logic [A_W-1:0] A0,
  input  logic [A_W-1:0] A1,
  input  logic [B_W-1:0] B0,
  input  logic [B_W-1:0] B1,
  input  logic [C_W-1:0] C0,
  input  logic [C_W-1:0] C1,
  input  logic           OP0,
  input  logic           OP1,
`ifdef DSP_ARB_LOCK_EN
  input  logic           LOCK0,
  input  logic           LOCK1,
`endif
  output logic [A_W-1:0] DSP_A,
  output logic [B_W-1:0] DSP_B,
  output logic [C_W-1:0] DSP_C,
  output logic [7:0]     DSP_OPMODE,
  output logic           DSP_CE,
  input  logic [P_W-1:0] P_IN,
  output logic           RES_VALID0,
  output logic           RES_VALID1,
  output logic [P_W-1:0] RES_DATA,
  output logic           BUSY
);

  logic           ptr_reg, ptr_next;
  logic           grant_id;
  logic           transfer;
  logic [A_W-1:0] a_reg;
  logic [B_W-1:0] b_reg;
  logic [C_W-1:0] c_reg;
  logic [7:0]     opmode_reg;
  logic           ce_reg;
  logic           issue_id_reg;
  logic           res_valid0_reg, res_valid1_reg;
  logic [P_W-1:0] res_data_reg;
  logic           tag_out_valid, tag_out_id, tag_busy;

`ifdef DSP_ARB_LOCK_EN
  logic lock_reg, lock_next;
`endif

  always_comb begin
    grant_id = (VALID0 && VALID1) ? ptr_reg : VALID1;
    transfer = !RST && (VALID0 || VALID1);
    READY0   = transfer && !grant_id;
    READY1   = transfer && grant_id;
    ptr_next = ptr_reg;
`ifdef DSP_ARB_LOCK_EN
    lock_next = lock_reg;
    if (transfer) begin
      lock_next = grant_id ? LOCK1 : LOCK0;
      ptr_next  = lock_next ? grant_id : !grant_id;
    end else if (lock_reg && !(ptr_reg ? VALID1 : VALID0)) begin
      // Locked owner dropped VALID: release and hand priority to the other side.
      lock_next = 1'b0;
      ptr_next  = !ptr_reg;
    end
`else
    if (transfer) begin
      ptr_next = !grant_id;
    end
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr_reg      <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
      c_reg        <= '0;
      opmode_reg   <= OPMODE_IDLE;
      ce_reg       <= 1'b0;
      issue_id_reg <= 1'b0;
`ifdef DSP_ARB_LOCK_EN
      lock_reg     <= 1'b0;
`endif
    end else begin
      ptr_reg <= ptr_next;
      ce_reg  <= transfer;
`ifdef DSP_ARB_LOCK_EN
      lock_reg <= lock_next;
`endif
      if (transfer) begin
        a_reg        <= grant_id ? A1 : A0;
        b_reg        <= grant_id ? B1 : B0;
        c_reg        <= grant_id ? C1 : C0;
        opmode_reg   <= opmode_of(grant_id ? OP1 : OP0);
        issue_id_reg <= grant_id;
      end
    end
  end

  dsp_tag_pipe #(
    .PIPE_LAT (PIPE_LAT)
  ) u_tag_pipe (
    .clk       (CLK),
    .rst       (RST),
    .in_valid  (ce_reg),
    .in_id     (issue_id_reg),
    .out_valid (tag_out_valid),
    .out_id    (tag_out_id),
    .any_valid (tag_busy)
  );

  // The tag leaving the pipe marks the cycle its result sits on P_IN.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      res_valid0_reg <= 1'b0;
      res_valid1_reg <= 1'b0;
      res_data_reg   <= '0;
    end else begin
      res_valid0_reg <= tag_out_valid && !tag_out_id;
      res_valid1_reg <= tag_out_valid && tag_out_id;
      if (tag_out_valid) begin
        res_data_reg <= P_IN;
      end
    end
  end

  assign DSP_A      = a_reg;
  assign DSP_B      = b_reg;
  assign DSP_C      = c_reg;
  assign DSP_OPMODE = opmode_reg;
  assign DSP_CE     = ce_reg;
  assign RES_VALID0 = res_valid0_reg;
  assign RES_VALID1 = res_valid1_reg;
  assign RES_DATA   = res_data_reg;
  assign BUSY       = ce_reg || tag_busy;

endmodule

// File: tb/tb_dsp_share_arbiter.sv
// Directed bench for dsp_share_arbiter: three instances (PIPE_LAT 4, 1, 8)
// share stimulus, each fed by a behavioural DSP slice model.
module tb_dsp_share_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        valid0, valid1, op0, op1;
  logic [17:0] a0, a1, b0, b1;
  logic [47:0] c0, c1;
`ifdef DSP_ARB_LOCK_EN
  logic        lock0, lock1;
`endif

  logic        rdy0_w [3];
  logic        rdy1_w [3];
  logic        ce_w   [3];
  logic        rv0_w  [3];
  logic        rv1_w  [3];
  logic        busy_w [3];
  logic [17:0] da_w   [3];
  logic [17:0] db_w   [3];
  logic [47:0] dc_w   [3];
  logic [7:0]  dop_w  [3];
  logic [47:0] pin_w  [3];
  logic [47:0] rdata_w[3];

  int n_cmp = 0;
  int n_bad = 0;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int LAT = (k == 0) ? 4 : ((k == 1) ? 1 : 8);
    logic [47:0] ppipe [LAT];

    dsp_share_arbiter #(.PIPE_LAT(LAT)) u_dut (
      .CLK(clk), .RST(rst), .VALID0(valid0), .VALID1(valid1),
      .READY0(rdy0_w[k]), .READY1(rdy1_w[k]),
      .A0(a0), .A1(a1), .B0(b0), .B1(b1), .C0(c0), .C1(c1),
      .OP0(op0), .OP1(op1),
`ifdef DSP_ARB_LOCK_EN
      .LOCK0(lock0), .LOCK1(lock1),
`endif
      .DSP_A(da_w[k]), .DSP_B(db_w[k]), .DSP_C(dc_w[k]),
      .DSP_OPMODE(dop_w[k]), .DSP_CE(ce_w[k]), .P_IN(pin_w[k]),
      .RES_VALID0(rv0_w[k]), .RES_VALID1(rv1_w[k]),
      .RES_DATA(rdata_w[k]), .BUSY(busy_w[k])
    );

    // DSP slice model: P = A*B (+C for MADD), valid LAT cycles after CE.
    always @(posedge clk) begin
      ppipe[0] <= ce_w[k] ? (({30'd0, da_w[k]} * {30'd0, db_w[k]}) +
                             ((dop_w[k] == 8'h0D) ? dc_w[k] : 48'd0)) : 48'd0;
      for (int i = 1; i < LAT; i++) ppipe[i] <= ppipe[i-1];
    end
    assign pin_w[k] = ppipe[LAT-1];
  end

  task automatic idle_inputs();
    valid0 = 0; valid1 = 0; op0 = 0; op1 = 0;
    a0 = 0; a1 = 0; b0 = 0; b1 = 0; c0 = 0; c1 = 0;
`ifdef DSP_ARB_LOCK_EN
    lock0 = 0; lock1 = 0;
`endif
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    repeat (2) @(negedge clk);
    valid0 = 1; valid1 = 1;
    #1;
    n_cmp++; if (rdy0_w[0] !== 1'b0) begin n_bad++; $display("FAIL reset_ready0 got=%b want=0", rdy0_w[0]); end
    n_cmp++; if (rdy1_w[0] !== 1'b0) begin n_bad++; $display("FAIL reset_ready1 got=%b want=0", rdy1_w[0]); end
    n_cmp++; if (ce_w[0] !== 1'b0) begin n_bad++; $display("FAIL reset_ce got=%b want=0", ce_w[0]); end
    n_cmp++; if (dop_w[0] !== 8'h00) begin n_bad++; $display("FAIL reset_opmode got=%h want=00", dop_w[0]); end
    n_cmp++; if ({da_w[0], db_w[0], dc_w[0]} !== 84'd0) begin n_bad++; $display("FAIL reset_operands got a=%0d b=%0d c=%0d want 0", da_w[0], db_w[0], dc_w[0]); end
    n_cmp++; if ({rv0_w[0], rv1_w[0], busy_w[0]} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got rv0=%b rv1=%b busy=%b want 000", rv0_w[0], rv1_w[0], busy_w[0]); end
    n_cmp++; if (rdata_w[0] !== 48'd0) begin n_bad++; $display("FAIL reset_res_data got=%0d want=0", rdata_w[0]); end
    @(negedge clk);
    valid0 = 0; valid1 = 0;
    rst = 0;
  endtask

  task automatic test_single();
    @(negedge clk);
    valid0 = 1; a0 = 3; b0 = 5; op0 = 0;
    #1;
    n_cmp++; if (rdy0_w[0] !== 1'b1 || rdy1_w[0] !== 1'b0) begin n_bad++; $display("FAIL single_ready got r0=%b r1=%b want 10", rdy0_w[0], rdy1_w[0]); end
    @(negedge clk);
    valid0 = 0; a0 = 0; b0 = 0;
    n_cmp++; if (ce_w[0] !== 1'b1) begin n_bad++; $display("FAIL single_ce got=%b want=1", ce_w[0]); end
    n_cmp++; if (dop_w[0] !== 8'h01) begin n_bad++; $display("FAIL single_opmode got=%h want=01", dop_w[0]); end
    n_cmp++; if (da_w[0] !== 18'd3 || db_w[0] !== 18'd5) begin n_bad++; $display("FAIL single_operands got a=%0d b=%0d want 3 5", da_w[0], db_w[0]); end
    n_cmp++; if (busy_w[0] !== 1'b1) begin n_bad++; $display("FAIL single_busy got=%b want=1", busy_w[0]); end
    for (int n = 2; n <= 8; n++) begin
      @(negedge clk);
      if (n == 2) begin
        n_cmp++; if (ce_w[0] !== 1'b0 || da_w[0] !== 18'd3) begin n_bad++; $display("FAIL single_hold got ce=%b a=%0d want 0 3", ce_w[0], da_w[0]); end
      end
      n_cmp++; if (rv0_w[0] !== (n == 6) || rv1_w[0] !== 1'b0) begin n_bad++; $display("FAIL single_res_valid cycle=%0d got rv0=%b rv1=%b want rv0=%b rv1=0", n, rv0_w[0], rv1_w[0], (n == 6)); end
      if (n == 6) begin
        n_cmp++; if (rdata_w[0] !== 48'd15) begin n_bad++; $display("FAIL single_res_data got=%0d want=15", rdata_w[0]); end
      end
    end
  endtask

  task automatic test_round_robin();
    int exp_id   [6] = '{0, 1, 0, 1, 0, 1};
    int exp_data [6] = '{2, 6, 6, 12, 10, 18};
    apply_reset();
    for (int n = 0; n <= 12; n++) begin
      @(negedge clk);
      if (n < 6) begin
        valid0 = 1; valid1 = 1;
        a0 = 18'(n + 1); b0 = 18'd2; a1 = 18'(n + 1); b1 = 18'd3;
        #1;
        n_cmp++; if (rdy0_w[0] !== (exp_id[n] == 0) || rdy1_w[0] !== (exp_id[n] == 1)) begin n_bad++; $display("FAIL rr_grant cycle=%0d got r0=%b r1=%b want id %0d", n, rdy0_w[0], rdy1_w[0], exp_id[n]); end
      end else begin
        valid0 = 0; valid1 = 0;
      end
      if (n >= 6 && n < 12) begin
        n_cmp++; if (rv0_w[0] !== (exp_id[n-6] == 0) || rv1_w[0] !== (exp_id[n-6] == 1) || rdata_w[0] !== 48'(exp_data[n-6])) begin n_bad++; $display("FAIL rr_result cycle=%0d got rv0=%b rv1=%b data=%0d want id %0d data %0d", n, rv0_w[0], rv1_w[0], rdata_w[0], exp_id[n-6], exp_data[n-6]); end
      end else begin
        n_cmp++; if (rv0_w[0] !== 1'b0 || rv1_w[0] !== 1'b0) begin n_bad++; $display("FAIL rr_no_result cycle=%0d got rv0=%b rv1=%b want 00", n, rv0_w[0], rv1_w[0]); end
      end
    end
  endtask

  task automatic test_madd();
    @(negedge clk);
    valid1 = 1; op1 = 1; a1 = 2; b1 = 7; c1 = 100;
    #1;
    n_cmp++; if (rdy1_w[0] !== 1'b1 || rdy0_w[0] !== 1'b0) begin n_bad++; $display("FAIL madd_ready got r0=%b r1=%b want 01", rdy0_w[0], rdy1_w[0]); end
    @(negedge clk);
    idle_inputs();
    n_cmp++; if (dop_w[0] !== 8'h0D || ce_w[0] !== 1'b1) begin n_bad++; $display("FAIL madd_opmode got op=%h ce=%b want 0d 1", dop_w[0], ce_w[0]); end
    n_cmp++; if (dc_w[0] !== 48'd100) begin n_bad++; $display("FAIL madd_dsp_c got=%0d want=100", dc_w[0]); end
    for (int n = 2; n <= 8; n++) begin
      @(negedge clk);
      n_cmp++; if (rv1_w[0] !== (n == 6) || rv0_w[0] !== 1'b0) begin n_bad++; $display("FAIL madd_res_valid cycle=%0d got rv0=%b rv1=%b want rv1=%b", n, rv0_w[0], rv1_w[0], (n == 6)); end
      if (n == 6) begin
        n_cmp++; if (rdata_w[0] !== 48'd114) begin n_bad++; $display("FAIL madd_res_data got=%0d want=114", rdata_w[0]); end
      end
    end
  endtask

  task automatic test_reset_in_flight();
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      valid0 = 1; valid1 = 1; a0 = 1; b0 = 1; a1 = 1; b1 = 1;
    end
    @(negedge clk);
    idle_inputs();
    rst = 1;
    #1;
    n_cmp++; if (busy_w[0] !== 1'b0 || ce_w[0] !== 1'b0 || da_w[0] !== 18'd0) begin n_bad++; $display("FAIL flight_async_clear got busy=%b ce=%b a=%0d want 0 0 0", busy_w[0], ce_w[0], da_w[0]); end
    @(negedge clk);
    rst = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      n_cmp++; if ({rv0_w[0], rv1_w[0], busy_w[0]} !== 3'b000) begin n_bad++; $display("FAIL flight_discard cycle=%0d got rv0=%b rv1=%b busy=%b want 000", n, rv0_w[0], rv1_w[0], busy_w[0]); end
    end
    valid0 = 1; valid1 = 1;
    #1;
    n_cmp++; if (rdy0_w[0] !== 1'b1 || rdy1_w[0] !== 1'b0) begin n_bad++; $display("FAIL flight_pointer got r0=%b r1=%b want 10", rdy0_w[0], rdy1_w[0]); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_latency();
    int lat_exp [3] = '{6, 3, 10};
    int seen_at [3] = '{-1, -1, -1};
    logic [47:0] seen_data [3];
    for (int k = 0; k < 3; k++) seen_data[k] = '0;
    apply_reset();
    @(negedge clk);
    valid0 = 1; a0 = 4; b0 = 4; op0 = 0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      valid0 = 0;
      for (int k = 0; k < 3; k++) begin
        if (seen_at[k] < 0 && rv0_w[k] === 1'b1) begin
          seen_at[k] = n;
          seen_data[k] = rdata_w[k];
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (seen_at[k] != lat_exp[k]) begin n_bad++; $display("FAIL latency_inst%0d got=%0d want=%0d", k, seen_at[k], lat_exp[k]); end
      n_cmp++; if (seen_data[k] !== 48'd16) begin n_bad++; $display("FAIL latency_data_inst%0d got=%0d want=16", k, seen_data[k]); end
    end
  endtask

`ifdef DSP_ARB_LOCK_EN
  task automatic test_lock();
    int exp_id [4] = '{0, 0, 0, 1};
    apply_reset();
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      valid1 = 1;
      valid0 = (n < 3);
      lock0  = (n < 3);
      #1;
      n_cmp++; if (rdy0_w[0] !== (exp_id[n] == 0) || rdy1_w[0] !== (exp_id[n] == 1)) begin n_bad++; $display("FAIL lock_grant cycle=%0d got r0=%b r1=%b want id %0d", n, rdy0_w[0], rdy1_w[0], exp_id[n]); end
    end
    @(negedge clk);
    idle_inputs();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_madd();
    test_reset_in_flight();
    test_latency();
`ifdef DSP_ARB_LOCK_EN
    test_lock();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
